// File: rtl/lockpick_game_gen2.sv
// rtl/lockpick_game_gen2.sv - two-key XOR, iterated Feistel hash, target compare, streamed result
// Optional runtime target loading over tgt_we/tgt_data: define LOCKPICK_TARGET_LOAD_EN.
module lockpick_game_gen2 #(
    parameter int           KEY_BYTES      = 32,
    parameter int           ROUNDS         = 3,
    parameter int           MAX_ATTEMPTS   = 3,
    parameter int           LOCKOUT_CYCLES = 1024,
    parameter logic [255:0] TARGET         = 256'hCAFEBABE_12345678_DEADBEEF_FEEDFACE_C001D00D_BADC0DE5_BAADF00D_0BADBEEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
`ifdef LOCKPICK_TARGET_LOAD_EN
    input  logic       tgt_we,
    input  logic [7:0] tgt_data,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [1:0] status,
    output logic [2:0] attempts_left,
    output logic       busy
);
    localparam int W     = KEY_BYTES * 8;
    localparam int L     = W / 4;
    localparam int CW    = $clog2(KEY_BYTES);
    localparam int HR    = (ROUNDS < 1) ? 1 : ROUNDS;
    localparam int CDW   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int ROT_F = 13 % L;
    localparam int ROT_B = L / 2 + 1;
    localparam int ROT_A = L / 4;
    localparam logic [W-1:0] TGT_INIT = W'(TARGET);
    localparam logic [31:0]  PAT_WIN  = 32'hFACEFACE;
    localparam logic [31:0]  PAT_LOCK = 32'hDEADDEAD;
    localparam logic [31:0]  PAT_ERR  = 32'hBAD0BAD0;

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, HASH, COMPARE, EMIT, COOLDOWN} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_nxt;
    logic [3:0]     round_q;
    logic [CDW-1:0] cool_q;
    logic [2:0]     fail_q;
    logic [2:0]     fail_d;
    logic [1:0]     status_q;
    logic [2:0]     attempts_q;
    logic [31:0]    pat_q;
    logic           out_valid_q;
    logic [7:0]     out_data_q;
    logic [W-1:0]   key_a_q;
    logic [W-1:0]   key_b_q;
    logic [W-1:0]   hash_q;
    logic [W-1:0]   hash_src;
    logic [W-1:0]   hash_d;
    logic [W-1:0]   target;
    logic           match;
    logic           lock_hit;
    logic [31:0]    pat_cmp;
    logic [1:0]     status_cmp;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [L-1:0] rotl(input logic [L-1:0] x, input int n);
        return (x << n) | (x >> (L - n));
    endfunction

    function automatic logic [W-1:0] hround(input logic [W-1:0] s);
        logic [L-1:0] a, b, c, d, f;
        a = s[4*L-1:3*L];
        b = s[3*L-1:2*L];
        c = s[2*L-1:L];
        d = s[L-1:0];
        f = ((b ^ d) + (a | c)) ^ {c[L/2-1:0], d[L/2-1:0]};
        for (int i = 0; i < L / 8; i++) f[i*8 +: 8] = {f[i*8 +: 7], f[i*8+7]};
        f = rotl(f, ROT_F);
        for (int i = 0; i < L / 8; i++) f[i*8 +: 8] = sbox(f[i*8 +: 8]);
        a = a ^ f;
        b = rotl(b, ROT_B);
        c = c + a;
        d = ~d ^ b;
        a = rotl(a, ROT_A);
        return {a, b, c, d};
    endfunction

`ifdef LOCKPICK_TARGET_LOAD_EN
    logic [W-1:0] tgt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_q <= TGT_INIT;
        end else if (tgt_we && state_q == IDLE) begin
            tgt_q <= {tgt_data, tgt_q[W-1:8]};
        end
    end
    assign target = tgt_q;
`else
    assign target = TGT_INIT;
`endif

    // The first round consumes the key XOR directly, so HASH needs no separate load cycle.
    always_comb begin
        hash_src   = (round_q == 4'd0) ? (key_a_q ^ key_b_q) : hash_q;
        hash_d     = (ROUNDS == 0) ? hash_src : hround(hash_src);
        match      = (hash_q == target);
        fail_d     = fail_q + 3'd1;
        lock_hit   = (fail_d == 3'(MAX_ATTEMPTS));
        cnt_nxt    = cnt_q + CW'(1);
        pat_cmp    = match ? PAT_WIN : (lock_hit ? PAT_LOCK : PAT_ERR);
        status_cmp = match ? 2'b10 : (lock_hit ? 2'b11 : 2'b01);
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            if (state_q == LOAD_A) key_a_q[{cnt_q, 3'b000} +: 8] <= in_data;
            else                   key_b_q[{cnt_q, 3'b000} +: 8] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            round_q     <= '0;
            cool_q      <= '0;
            fail_q      <= '0;
            status_q    <= 2'b00;
            attempts_q  <= 3'(MAX_ATTEMPTS);
            pat_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            hash_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) state_q <= LOAD_A;
                LOAD_A, LOAD_B: begin
                    if (in_valid) begin
                        if (cnt_q == CW'(KEY_BYTES - 1)) begin
                            cnt_q   <= '0;
                            round_q <= '0;
                            state_q <= (state_q == LOAD_A) ? LOAD_B : HASH;
                        end else begin
                            cnt_q <= cnt_nxt;
                        end
                    end
                end
                HASH: begin
                    hash_q  <= hash_d;
                    round_q <= round_q + 4'd1;
                    if (round_q == 4'(HR - 1)) state_q <= COMPARE;
                end
                COMPARE: begin
                    status_q    <= status_cmp;
                    pat_q       <= pat_cmp;
                    out_data_q  <= pat_cmp[7:0];
                    out_valid_q <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= EMIT;
                    if (!match) begin
                        fail_q     <= fail_d;
                        attempts_q <= 3'(MAX_ATTEMPTS) - fail_d;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (cnt_q == CW'(KEY_BYTES - 1)) begin
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            cnt_q       <= '0;
                            if (status_q == 2'b10) begin
                                state_q    <= IDLE;
                                fail_q     <= '0;
                                status_q   <= 2'b00;
                                attempts_q <= 3'(MAX_ATTEMPTS);
                            end else if (status_q == 2'b11) begin
                                cool_q  <= '0;
                                state_q <= COOLDOWN;
                            end else begin
                                state_q <= LOAD_A;
                            end
                        end else begin
                            cnt_q      <= cnt_nxt;
                            out_data_q <= pat_q[{cnt_nxt[1:0], 3'b000} +: 8];
                        end
                    end
                end
                COOLDOWN: begin
                    if (cool_q == CDW'(LOCKOUT_CYCLES - 1)) begin
                        state_q    <= IDLE;
                        fail_q     <= '0;
                        status_q   <= 2'b00;
                        attempts_q <= 3'(MAX_ATTEMPTS);
                    end else begin
                        cool_q <= cool_q + CDW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign busy          = (state_q != IDLE);
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign status        = status_q;
    assign attempts_left = attempts_q;
endmodule

// File: tb/tb_lockpick_game_gen2.sv
// tb/tb_lockpick_game_gen2.sv - directed bench: win, lockout/cooldown, stalls, reset, hash reference
module tb_lockpick_game_gen2;
    localparam logic [255:0] TGT = 256'hCAFEBABE_12345678_DEADBEEF_FEEDFACE_C001D00D_BADC0DE5_BAADF00D_0BADBEEF;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       ir0, ov0, b0, ir1, ov1, b1;
    logic [7:0] od0, od1;
    logic [1:0] st0, st1;
    logic [2:0] al0, al1;
    bit         sel = 1'b0;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    lockpick_game_gen2 #(.KEY_BYTES(32), .ROUNDS(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .status(st0), .attempts_left(al0), .busy(b0)
    );

    lockpick_game_gen2 #(.KEY_BYTES(16), .ROUNDS(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .status(st1), .attempts_left(al1), .busy(b1)
    );

    wire       obs_valid = sel ? ov1 : ov0;
    wire [7:0] obs_data  = sel ? od1 : od0;
    wire [1:0] obs_stat  = sel ? st1 : st0;
    wire [2:0] obs_att   = sel ? al1 : al0;
    wire       obs_busy  = sel ? b1 : b0;
    wire       obs_ready = sel ? ir1 : ir0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box from first principles: GF(2^8) inverse (v^254) then the affine map.
    function automatic logic [7:0] ref_sbox(input logic [7:0] v);
        logic [7:0] inv, sq;
        inv = 8'h01;
        sq  = v;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s);
        logic [31:0] a, b, c, d, f;
        logic [7:0]  t;
        a = s[127:96]; b = s[95:64]; c = s[63:32]; d = s[31:0];
        f = ((b ^ d) + (a | c)) ^ {c[15:0], d[15:0]};
        for (int j = 0; j < 4; j++) begin
            t = f[j*8 +: 8];
            f[j*8 +: 8] = {t[6:0], t[7]};
        end
        f = {f[18:0], f[31:19]};
        for (int j = 0; j < 4; j++) f[j*8 +: 8] = ref_sbox(f[j*8 +: 8]);
        a = a ^ f;
        b = {b[14:0], b[31:15]};
        c = c + a;
        d = ~d ^ b;
        a = {a[23:0], a[31:24]};
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] ref_hash(input logic [127:0] x);
        logic [127:0] h;
        h = x;
        for (int r = 0; r < 3; r++) h = ref_round(h);
        return h;
    endfunction

    task automatic begin_game();
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        check("in_ready_load_a", obs_ready, 1);
        check("busy_load_a", obs_busy, 1);
    endtask

    task automatic send_key(input logic [255:0] key, input bit gaps, input bit pulse);
        int n;
        n = sel ? 16 : 32;
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 3 == 1)) begin
                in_valid = 1'b0;
                in_data  = 8'(i * 37 + 5);
                if (pulse && i == 4) begin
                    if (sel) start1 = 1'b1; else start0 = 1'b1;
                end
                @(negedge clk);
                start0 = 1'b0;
                start1 = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = key[i*8 +: 8];
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // lat counts the acceptance cycle of the last key byte as cycle 1.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!obs_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("valid_timeout", (lat < 100), 1);
    endtask

    task automatic recv(input logic [31:0] pat, input bit rnd);
        int         n, got, guard;
        bit         stalled, rdy;
        logic [7:0] prev;
        n = sel ? 16 : 32;
        got = 0; guard = 0; stalled = 1'b0; prev = 8'h00;
        while (got < n && guard < 2000) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (obs_valid) begin
                if (stalled) check("stall_stable", obs_data, prev);
                if (rdy) begin
                    check($sformatf("emit_byte%0d", got), obs_data, pat[(got % 4) * 8 +: 8]);
                    got++;
                    stalled = 1'b0;
                end else begin
                    prev = obs_data;
                    stalled = 1'b1;
                end
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        check("emit_count", got, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, cnt;
        logic [127:0] ka, kb;

        repeat (3) @(negedge clk);
        check("rst_out_valid", ov0, 0);
        check("rst_out_data", od0, 0);
        check("rst_status", st0, 0);
        check("rst_attempts", al0, 3);
        check("rst_busy", b0, 0);
        check("rst_in_ready", ir0, 0);
        check("rst_u1_attempts", al1, 3);
        rst = 1'b1;
        @(negedge clk);

        // Win on the identity-hash instance with input gaps and a stray start in LOAD_B.
        sel = 1'b0;
        begin_game();
        send_key(TGT, 1'b1, 1'b0);
        check("in_ready_load_b", obs_ready, 1);
        send_key(256'h0, 1'b1, 1'b1);
        wait_valid(lat);
        check("win_status", obs_stat, 2'b10);
        recv(32'hFACEFACE, 1'b0);
        check("win_idle_busy", obs_busy, 0);
        check("win_idle_status", obs_stat, 2'b00);
        check("win_idle_attempts", obs_att, 3);
        check("win_idle_out_valid", obs_valid, 0);

        // Three misses: error, error, lockout, then a cooldown that ignores start.
        begin_game();
        for (int a = 0; a < 3; a++) begin
            send_key(256'h0, 1'b0, 1'b0);
            send_key(256'h0, 1'b0, 1'b0);
            wait_valid(lat);
            check($sformatf("miss%0d_status", a), obs_stat, (a < 2) ? 2'b01 : 2'b11);
            check($sformatf("miss%0d_attempts", a), obs_att, 2 - a);
            recv((a < 2) ? 32'hBAD0BAD0 : 32'hDEADDEAD, (a == 1));
            if (a < 2) check($sformatf("miss%0d_reload", a), obs_ready, 1);
        end
        start0 = 1'b1;
        cnt = 0;
        while (obs_busy && cnt < 2000) begin
            if (cnt == 100) start0 = 1'b0;
            if (cnt == 500) check("cooldown_status", obs_stat, 2'b11);
            @(negedge clk);
            cnt++;
        end
        start0 = 1'b0;
        check("cooldown_len", cnt, 1024);
        check("post_cool_status", obs_stat, 2'b00);
        check("post_cool_attempts", obs_att, 3);
        @(negedge clk);
        check("post_cool_idle", obs_busy, 0);

        // Three-round instance: latency and bit-exact hash against the reference rounds.
        sel = 1'b1;
        begin_game();
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        send_key({128'h0, ka}, 1'b0, 1'b0);
        send_key({128'h0, kb}, 1'b0, 1'b0);
        wait_valid(lat);
        check("latency_r3", lat, 5);
        check("hash_ref", u1.hash_q, ref_hash(ka ^ kb));
        check("r3_status", obs_stat, 2'b01);
        check("r3_attempts", obs_att, 2);
        recv(32'hBAD0BAD0, 1'b1);

        // Reset in the middle of HASH, then a fresh game.
        send_key({128'h0, ka}, 1'b0, 1'b0);
        send_key({128'h0, kb}, 1'b0, 1'b0);
        check("in_hash_busy", obs_busy, 1);
        rst = 1'b0;
        #1;
        check("midrst_busy", obs_busy, 0);
        check("midrst_status", obs_stat, 2'b00);
        check("midrst_out_valid", obs_valid, 0);
        check("midrst_attempts", obs_att, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        begin_game();
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        send_key({128'h0, ka}, 1'b0, 1'b0);
        send_key({128'h0, kb}, 1'b0, 1'b0);
        wait_valid(lat);
        check("latency_r3_b", lat, 5);
        check("hash_ref_b", u1.hash_q, ref_hash(ka ^ kb));
        check("post_rst_status", obs_stat, 2'b01);
        check("post_rst_attempts", obs_att, 2);
        recv(32'hBAD0BAD0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
